// File: rtl/btn_scan_pkg.sv
// Shared types for the button scan controller: event record, scan FSM states
// and a width helper used to size indices and counters.
package btn_scan_pkg;

    // Event code field is sized for the largest panel supported; users slice it.
    localparam int unsigned CODE_W_MAX = 8;

    typedef struct packed {
        logic [CODE_W_MAX-1:0] code;
        logic                  press;
        logic                  rpt;
    } evt_t;

    typedef enum logic [1:0] {
        WAIT,
        EVAL,
        COMMIT
    } scan_state_t;

    // Bits needed to hold values 0..n-1 (at least one bit).
    function automatic int unsigned width_of(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/btn_scan_ctrl_fifo.sv
// evt_fifo: small synchronous FIFO of button events.
// DEPTH must be a power of two so the pointers wrap naturally.
module evt_fifo
    import btn_scan_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic push,
    input  evt_t push_data,
    input  logic pop,
    output evt_t head,
    output logic full,
    output logic empty
);

    localparam int unsigned AW  = width_of(DEPTH);
    localparam int unsigned CNW = AW + 1;

    evt_t            mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CNW-1:0]  count;
    logic            do_push;
    logic            do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full FIFO still lands when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/btn_scan_ctrl.sv
// btn_scan_ctrl: round-robin debounce of N_BTN buttons with one shared filter,
// press/release events queued to a valid/ready consumer.
// Optional build macro AUTOREPEAT_EN adds per-channel hold counters that emit
// auto-repeat press events; without it evt_repeat is tied low.
module btn_scan_ctrl
    import btn_scan_pkg::*;
#(
    parameter int unsigned N_BTN      = 4,
    parameter int unsigned TICK_DIV   = 1000,
    parameter int unsigned STABLE_CNT = 4,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned REPEAT_DLY = 64
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [N_BTN-1:0]            btn_in,
    output logic [N_BTN-1:0]            btn_state,
    output logic                        evt_valid,
    input  logic                        evt_ready,
    output logic [width_of(N_BTN)-1:0]  evt_code,
    output logic                        evt_press,
    output logic                        evt_repeat,
    output logic                        overflow,
    input  logic                        clr_overflow
);

    localparam int unsigned CW = width_of(N_BTN);
    localparam int unsigned PW = width_of(TICK_DIV);
    localparam int unsigned SW = width_of(STABLE_CNT);

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] CNT_LAST   = SW'(STABLE_CNT - 1);
    localparam logic [CW-1:0] PTR_LAST   = CW'(N_BTN - 1);

    logic [N_BTN-1:0] sync1;
    logic [N_BTN-1:0] sync2;
    logic [PW-1:0]    presc;
    logic             slot_tick;
    scan_state_t      state;
    scan_state_t      next_state;
    logic [CW-1:0]    ptr;
    logic [SW-1:0]    cnt [N_BTN];
    logic             sample;
    logic             commit;
    logic             commit_level;
    logic             commit_rpt;
    logic             push;
    logic             pop;
    logic             drop;
    logic             fifo_full;
    logic             fifo_empty;
    evt_t             push_data;
    evt_t             head;
    logic             unused_head;

`ifdef AUTOREPEAT_EN
    localparam int unsigned   HW        = width_of(REPEAT_DLY);
    localparam logic [HW-1:0] HOLD_LAST = HW'(REPEAT_DLY - 1);
    logic [HW-1:0] hold [N_BTN];
`endif

    assign slot_tick = (presc == PRESC_LAST);
    assign sample    = sync2[ptr];

    // Two-flop synchroniser on every raw button line.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_in;
            sync2 <= sync1;
        end
    end

    // Slot prescaler: slot_tick marks the last cycle of each scan slot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc <= '0;
        end else begin
            presc <= slot_tick ? '0 : presc + 1'b1;
        end
    end

    // Scan FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= WAIT;
        end else begin
            state <= next_state;
        end
    end

    // Scan FSM sequencing: one evaluate/commit pair per slot.
    always_comb begin
        next_state = state;
        case (state)
            WAIT:    if (slot_tick) next_state = EVAL;
            EVAL:    next_state = COMMIT;
            COMMIT:  next_state = WAIT;
            default: next_state = WAIT;
        endcase
    end

    // Shared debounce filter applied to the channel under ptr; pointer advance.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_state    <= '0;
            ptr          <= '0;
            commit       <= 1'b0;
            commit_level <= 1'b0;
            commit_rpt   <= 1'b0;
            for (int unsigned i = 0; i < N_BTN; i++) begin
                cnt[i] <= '0;
            end
`ifdef AUTOREPEAT_EN
            for (int unsigned i = 0; i < N_BTN; i++) begin
                hold[i] <= '0;
            end
`endif
        end else begin
            case (state)
                EVAL: begin
                    commit       <= 1'b0;
                    commit_rpt   <= 1'b0;
                    commit_level <= sample;
                    if (sample == btn_state[ptr]) begin
                        cnt[ptr] <= '0;
                    end else if (cnt[ptr] != CNT_LAST) begin
                        cnt[ptr] <= cnt[ptr] + 1'b1;
                    end else begin
                        btn_state[ptr] <= sample;
                        cnt[ptr]       <= '0;
                        commit         <= 1'b1;
                    end
`ifdef AUTOREPEAT_EN
                    // Hold time only accrues while pressed and undisturbed;
                    // any differing sample (release in progress) restarts it.
                    if ((sample == btn_state[ptr]) && btn_state[ptr]) begin
                        if (hold[ptr] == HOLD_LAST) begin
                            hold[ptr]  <= '0;
                            commit     <= 1'b1;
                            commit_rpt <= 1'b1;
                        end else begin
                            hold[ptr] <= hold[ptr] + 1'b1;
                        end
                    end else begin
                        hold[ptr] <= '0;
                    end
`endif
                end
                COMMIT: begin
                    commit <= 1'b0;
                    ptr    <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Event record for the channel just evaluated.
    always_comb begin
        push_data       = '0;
        push_data.code  = CODE_W_MAX'(ptr);
        push_data.press = commit_level;
        push_data.rpt   = commit_rpt;
    end

    assign push = (state == COMMIT) && commit;
    assign pop  = evt_valid && evt_ready;
    assign drop = push && fifo_full && !pop;

    evt_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_overflow) begin
            overflow <= 1'b0;
        end
    end

    assign evt_valid = !fifo_empty;
    assign evt_code  = head.code[CW-1:0];
    assign evt_press = head.press;
`ifdef AUTOREPEAT_EN
    assign evt_repeat = head.rpt;
`else
    assign evt_repeat = 1'b0;
`endif
    assign unused_head = ^{head.code[CODE_W_MAX-1:CW], head.rpt};

endmodule

// File: tb/tb_btn_scan_ctrl.sv
// Directed bench for btn_scan_ctrl (N_BTN=4, TICK_DIV=4, STABLE_CNT=3,
// FIFO_DEPTH=4, REPEAT_DLY=5). Visit period per channel is 16 clk.
module tb_btn_scan_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] btn_in;
    logic [3:0] btn_state;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_code;
    logic       evt_press;
    logic       evt_repeat;
    logic       overflow;
    logic       clr_overflow;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;
    int unsigned cyc     = 0;
    int unsigned evt_cyc = 0;

    btn_scan_ctrl #(
        .N_BTN      (4),
        .TICK_DIV   (4),
        .STABLE_CNT (3),
        .FIFO_DEPTH (4),
        .REPEAT_DLY (5)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .btn_in       (btn_in),
        .btn_state    (btn_state),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_code     (evt_code),
        .evt_press    (evt_press),
        .evt_repeat   (evt_repeat),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Wait (bounded) for the FIFO head, compare it, then pop it.
    task automatic expect_evt(input string tag, input logic [1:0] code, input logic press, input logic rpt);
        int unsigned k;
        k = 0;
        while (!evt_valid && k < 400) begin
            @(negedge clk);
            k++;
        end
        check_eq({tag, "_valid"}, {31'd0, evt_valid}, 32'd1);
        if (evt_valid) begin
            evt_cyc = cyc;
            check_eq({tag, "_evt"}, {28'd0, evt_code, evt_press, evt_repeat}, {28'd0, code, press, rpt});
            evt_ready = 1'b1;
            @(negedge clk);
            evt_ready = 1'b0;
        end
    endtask

    // Wait (bounded) until the debounced state reaches target; returns in the commit cycle.
    task automatic wait_state(input string tag, input logic [3:0] target);
        int unsigned k;
        k = 0;
        while (btn_state !== target && k < 400) begin
            @(negedge clk);
            k++;
        end
        check_eq(tag, {28'd0, btn_state}, {28'd0, target});
    endtask

    task automatic no_evt(input string tag, input int unsigned n);
        logic seen;
        seen = 1'b0;
        for (int unsigned i = 0; i < n; i++) begin
            @(negedge clk);
            seen = seen | evt_valid;
        end
        check_eq(tag, {31'd0, seen}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [4:0] drain_exp [4];
        int unsigned t_rep;
        drain_exp[0] = 5'b1_00_1_0;
        drain_exp[1] = 5'b1_00_0_0;
        drain_exp[2] = 5'b1_01_1_0;
        drain_exp[3] = 5'b1_01_0_0;

        reset_n      = 1'b0;
        btn_in       = '0;
        evt_ready    = 1'b0;
        clr_overflow = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_outs", {22'd0, btn_state, evt_valid, evt_code, evt_press, evt_repeat, overflow}, 32'd0);
        reset_n = 1'b1;

        // 1: steady press on ch1 yields exactly one press event
        btn_in = 4'b0010;
        expect_evt("t1_press", 2'd1, 1'b1, 1'b0);
        check_eq("t1_state", {28'd0, btn_state}, 32'h2);
        no_evt("t1_single", 48);
        btn_in = 4'b0000;
        expect_evt("t1_release", 2'd1, 1'b0, 1'b0);

        // 2: glitch shorter than one visit period is filtered
        btn_in = 4'b0100;
        repeat (10) @(negedge clk);
        btn_in = 4'b0000;
        no_evt("t2_glitch", 64);
        check_eq("t2_state", {28'd0, btn_state}, 32'h0);

        // 3 + 6: six events into a 4-deep FIFO with no consumer
        btn_in = 4'b0001; wait_state("t3_p0", 4'b0001);
        btn_in = 4'b0000; wait_state("t3_r0", 4'b0000);
        btn_in = 4'b0010; wait_state("t3_p1", 4'b0010);
        btn_in = 4'b0000; wait_state("t3_r1", 4'b0000);
        @(negedge clk);
        check_eq("t3_no_ovf_yet", {31'd0, overflow}, 32'd0);
        btn_in = 4'b0100; wait_state("t3_p2", 4'b0100);
        // this cycle is the commit of a dropped event: clear collides with set
        clr_overflow = 1'b1;
        @(negedge clk);
        clr_overflow = 1'b0;
        check_eq("t6_set_wins", {31'd0, overflow}, 32'd1);
        btn_in = 4'b0000; wait_state("t3_r2", 4'b0000);
        repeat (2) @(negedge clk);
        check_eq("t3_ovf", {31'd0, overflow}, 32'd1);
        clr_overflow = 1'b1;
        @(negedge clk);
        clr_overflow = 1'b0;
        check_eq("t6_clr", {31'd0, overflow}, 32'd0);
        evt_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("t3_drain%0d", i),
                     {27'd0, evt_valid, evt_code, evt_press, evt_repeat}, {27'd0, drain_exp[i]});
            @(negedge clk);
        end
        evt_ready = 1'b0;
        check_eq("t3_empty", {31'd0, evt_valid}, 32'd0);

        // 4: asynchronous reset with two events pending
        btn_in = 4'b0001; wait_state("t4_p0", 4'b0001);
        btn_in = 4'b0011; wait_state("t4_p1", 4'b0011);
        repeat (2) @(negedge clk);
        check_eq("t4_queued", {28'd0, evt_valid, evt_code, evt_press}, {28'd0, 1'b1, 2'd0, 1'b1});
        #2 reset_n = 1'b0;
        #1;
        check_eq("t4_async_rst", {22'd0, btn_state, evt_valid, evt_code, evt_press, evt_repeat, overflow}, 32'd0);
        btn_in = 4'b1001;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        // scan restarts at ch0, so ch0 is accepted ahead of ch3
        expect_evt("t4_ch0_first", 2'd0, 1'b1, 1'b0);
        expect_evt("t4_ch3_next", 2'd3, 1'b1, 1'b0);

        // 5: hold ch3, release ch0
        btn_in = 4'b1000;
        expect_evt("t5_rel0", 2'd0, 1'b0, 1'b0);
`ifdef AUTOREPEAT_EN
        expect_evt("t5_rep1", 2'd3, 1'b1, 1'b1);
        t_rep = evt_cyc;
        expect_evt("t5_rep2", 2'd3, 1'b1, 1'b1);
        check_eq("t5_period", evt_cyc - t_rep, 32'd80);
`else
        t_rep = evt_cyc;
        no_evt("t5_no_repeat", 200);
`endif
        btn_in = 4'b0000;
        expect_evt("t5_rel3", 2'd3, 1'b0, 1'b0);
        check_eq("t5_state", {28'd0, btn_state}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
